// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Holds the program counter, issues one request per
// cycle to instruction memory, and captures each returned word in the IF/ID
// register. The captured word is then split into its opcode and operand
// fields for the decode stage.
//
// A small FSM controls fetching:
//   IDLE  - one cycle after reset is released
//   FETCH - normal fetching
//   HALT  - entered after a HALT_OP word is fetched; left only on redirect
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   stall             decode cannot accept a new instruction this cycle
//   flush             invalidate the IF/ID register
//   redirect          load redirect_pc into the PC; the current fetch is dropped
//   redirect_pc       target PC used when redirect=1
//   imem_req          request to instruction memory
//   imem_addr         fetch address (the current PC)
//   imem_ready        memory returns imem_rdata this cycle
//   imem_rdata        instruction word from memory
//   if_valid          IF/ID register holds a valid instruction
//   if_pc             PC of the instruction in IF/ID
//   op, rs, rt, rd    IF/ID fields [31:26], [25:21], [20:16], [15:11]
//   imm               IF/ID field [15:0]
//   op_legal          if_valid and op is add, sw, lw or HALT_OP
//   halted            fetch is stopped by HALT_OP
//   fetch_count       number of accepted transfers (wraps at 16 bits)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic        op_legal,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] if_pc_reg;
    logic        if_valid_reg;
    logic [15:0] fetch_count_reg;
    logic        transfer;

    // imem_req already excludes redirect, so a transfer never coincides with
    // a redirect.
    assign transfer = imem_req && imem_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state_reg)
                IDLE:    state_next = FETCH;
                // A flushed halt word is dropped like any other flushed
                // word, so it does not stop fetching.
                FETCH:   if (transfer && !flush && (imem_rdata[31:26] == HALT_OP))
                             state_next = HALT;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        imem_req = 1'b0;
        halted   = 1'b0;
        case (state_reg)
            FETCH:   imem_req = !(stall && if_valid_reg) && !redirect;
            HALT:    halted   = 1'b1;
            default: ;
        endcase
    end

    // ---------------- PC, IF/ID register and transfer counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            ir_reg          <= 32'd0;
            if_pc_reg       <= 32'd0;
            if_valid_reg    <= 1'b0;
            fetch_count_reg <= 16'd0;
        end else if (redirect) begin
            pc_reg       <= redirect_pc;
            if_valid_reg <= 1'b0;
        end else if (transfer) begin
            // PC and count advance even when the word itself is flushed.
            pc_reg          <= pc_reg + 32'd4;
            fetch_count_reg <= fetch_count_reg + 16'd1;
            if (flush) begin
                if_valid_reg <= 1'b0;
            end else begin
                ir_reg       <= imem_rdata;
                if_pc_reg    <= pc_reg;
                if_valid_reg <= 1'b1;
            end
        end else if (flush || !(stall && if_valid_reg)) begin
            // Bubble: fields hold their old values, only the valid drops.
            if_valid_reg <= 1'b0;
        end
    end

    // ---------------- field decode ----------------
    assign imem_addr   = pc_reg;
    assign if_valid    = if_valid_reg;
    assign if_pc       = if_pc_reg;
    assign op          = ir_reg[31:26];
    assign rs          = ir_reg[25:21];
    assign rt          = ir_reg[20:16];
    assign rd          = ir_reg[15:11];
    assign imm         = ir_reg[15:0];
    assign fetch_count = fetch_count_reg;

    localparam logic [3:0][5:0] LEGAL_OPS = {HALT_OP, 6'b000100, 6'b000010, 6'b000001};

    logic [3:0] op_match;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_legal
            assign op_match[gi] = (ir_reg[31:26] == LEGAL_OPS[gi]);
        end
    endgenerate

    assign op_legal = if_valid_reg && (|op_match);

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch: reset, back-to-back fetch, stall, bubble,
// redirect, halt, flush and asynchronous reset mid-operation. Instruction
// memory is a small word array addressed by imem_addr.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        op_legal;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .op_legal    (op_legal),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_rdata = mem[imem_addr[7:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic exp_valid,
                            input logic [31:0] exp_pc, input logic [5:0] exp_op);
        chk({tag, ".if_valid"}, 32'(if_valid), 32'(exp_valid));
        chk({tag, ".if_pc"},    if_pc,         exp_pc);
        chk({tag, ".op"},       32'(op),       32'(exp_op));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".imem_req"},    32'(imem_req),    32'd0);
        chk({tag, ".imem_addr"},   imem_addr,        32'd0);
        chk_ifid(tag, 1'b0, 32'd0, 6'd0);
        chk({tag, ".rs"},          32'(rs),          32'd0);
        chk({tag, ".rt"},          32'(rt),          32'd0);
        chk({tag, ".rd"},          32'(rd),          32'd0);
        chk({tag, ".imm"},         32'(imm),         32'd0);
        chk({tag, ".op_legal"},    32'(op_legal),    32'd0);
        chk({tag, ".halted"},      32'(halted),      32'd0);
        chk({tag, ".fetch_count"}, 32'(fetch_count), 32'd0);
    endtask

    // Global time bound; the directed sequence needs far less than this.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h0400_0000;  // add
        mem[1]  = 32'h0822_1805;  // sw  rs=1 rt=2 rd=3 imm=1805
        mem[2]  = 32'h1043_0010;  // lw  rs=2 rt=3 imm=0010
        mem[3]  = 32'h0400_00AA;  // add imm=00AA
        mem[4]  = 32'h0800_0000;  // sw
        mem[7]  = 32'h0800_0000;  // sw at 0x1C
        mem[16] = 32'h1000_0040;  // lw at 0x40
        mem[17] = 32'hFC00_0000;  // halt at 0x44
        mem[18] = 32'h0400_0000;  // must never be fetched while halted

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; imem_ready = 1'b1;

        // Reset state
        tick; tick;
        $display("step: reset state");
        chk_reset("rst");

        // Release: IDLE for exactly one cycle
        rst = 1'b0; #1;
        $display("step: idle cycle");
        chk("idle.imem_req", 32'(imem_req), 32'd0);
        tick;
        chk("fetch0.imem_req", 32'(imem_req), 32'd1);
        chk("fetch0.imem_addr", imem_addr, 32'd0);
        chk("fetch0.if_valid", 32'(if_valid), 32'd0);

        // Back-to-back add/sw/lw
        tick;
        $display("step: add at 0x0");
        chk_ifid("add", 1'b1, 32'h0, 6'b000001);
        chk("add.op_legal", 32'(op_legal), 32'd1);
        chk("add.imem_addr", imem_addr, 32'h4);
        chk("add.fetch_count", 32'(fetch_count), 32'd1);
        tick;
        $display("step: sw at 0x4");
        chk_ifid("sw", 1'b1, 32'h4, 6'b000010);
        chk("sw.rs", 32'(rs), 32'd1);
        chk("sw.rt", 32'(rt), 32'd2);
        chk("sw.rd", 32'(rd), 32'd3);
        chk("sw.imm", 32'(imm), 32'h1805);
        tick;
        $display("step: lw at 0x8");
        chk_ifid("lw", 1'b1, 32'h8, 6'b000100);
        chk("lw.rs", 32'(rs), 32'd2);
        chk("lw.rt", 32'(rt), 32'd3);
        chk("lw.imm", 32'(imm), 32'h0010);
        chk("lw.fetch_count", 32'(fetch_count), 32'd3);
        chk("lw.imem_addr", imem_addr, 32'hC);

        // Stall for 3 cycles with if_valid=1
        stall = 1'b1; #1;
        chk("stall.imem_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            $display("step: stall cycle %0d", i);
            chk_ifid("stall", 1'b1, 32'h8, 6'b000100);
            chk("stall.imem_req", 32'(imem_req), 32'd0);
            chk("stall.imem_addr", imem_addr, 32'hC);
            chk("stall.fetch_count", 32'(fetch_count), 32'd3);
        end
        stall = 1'b0; #1;
        chk("unstall.imem_req", 32'(imem_req), 32'd1);
        tick;
        $display("step: resume at 0xC");
        chk_ifid("resume", 1'b1, 32'hC, 6'b000001);
        chk("resume.imm", 32'(imm), 32'h00AA);
        chk("resume.fetch_count", 32'(fetch_count), 32'd4);

        // Bubble: ready low, no stall
        imem_ready = 1'b0;
        tick;
        $display("step: bubble");
        chk_ifid("bubble", 1'b0, 32'hC, 6'b000001);
        chk("bubble.imm", 32'(imm), 32'h00AA);
        chk("bubble.op_legal", 32'(op_legal), 32'd0);
        chk("bubble.fetch_count", 32'(fetch_count), 32'd4);
        chk("bubble.imem_addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        tick;
        $display("step: sw at 0x10");
        chk_ifid("sw10", 1'b1, 32'h10, 6'b000010);
        chk("sw10.fetch_count", 32'(fetch_count), 32'd5);

        // Redirect with ready=1: word at 0x14 discarded
        redirect = 1'b1; redirect_pc = 32'h40; #1;
        chk("redir.imem_req", 32'(imem_req), 32'd0);
        tick;
        redirect = 1'b0;
        $display("step: redirect to 0x40");
        chk_ifid("redir", 1'b0, 32'h10, 6'b000010);
        chk("redir.imem_addr", imem_addr, 32'h40);
        chk("redir.fetch_count", 32'(fetch_count), 32'd5);
        #1;
        chk("redir.imem_req_after", 32'(imem_req), 32'd1);
        tick;
        $display("step: lw at 0x40");
        chk_ifid("lw40", 1'b1, 32'h40, 6'b000100);
        chk("lw40.fetch_count", 32'(fetch_count), 32'd6);

        // Halt word
        tick;
        $display("step: halt at 0x44");
        chk_ifid("halt", 1'b1, 32'h44, 6'b111111);
        chk("halt.op_legal", 32'(op_legal), 32'd1);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.imem_req", 32'(imem_req), 32'd0);
        chk("halt.fetch_count", 32'(fetch_count), 32'd7);
        for (int i = 0; i < 10; i++) begin
            tick;
            $display("step: halted cycle %0d", i);
            chk("halted.halted", 32'(halted), 32'd1);
            chk("halted.imem_req", 32'(imem_req), 32'd0);
            chk("halted.imem_addr", imem_addr, 32'h48);
            chk("halted.fetch_count", 32'(fetch_count), 32'd7);
        end
        chk_ifid("halted_bubble", 1'b0, 32'h44, 6'b111111);

        // Redirect out of HALT
        redirect = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect = 1'b0;
        $display("step: redirect out of halt");
        chk("unhalt.halted", 32'(halted), 32'd0);
        chk("unhalt.imem_addr", imem_addr, 32'h0);
        #1;
        chk("unhalt.imem_req", 32'(imem_req), 32'd1);
        tick;
        $display("step: refetch add at 0x0");
        chk_ifid("refetch", 1'b1, 32'h0, 6'b000001);
        chk("refetch.fetch_count", 32'(fetch_count), 32'd8);

        // Flush on a transfer: word dropped, PC and count advance
        flush = 1'b1;
        tick;
        flush = 1'b0;
        $display("step: flush");
        chk_ifid("flush", 1'b0, 32'h0, 6'b000001);
        chk("flush.imem_addr", imem_addr, 32'h8);
        chk("flush.fetch_count", 32'(fetch_count), 32'd9);

        // Set up PC=0x20 with if_valid=1, then async reset
        redirect = 1'b1; redirect_pc = 32'h1C;
        tick;
        redirect = 1'b0;
        tick;
        $display("step: sw at 0x1C");
        chk_ifid("sw1c", 1'b1, 32'h1C, 6'b000010);
        chk("sw1c.imem_addr", imem_addr, 32'h20);
        chk("sw1c.fetch_count", 32'(fetch_count), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        $display("step: async reset");
        chk_reset("arst");
        tick;
        $display("step: reset held over edge");
        chk_reset("arst_hold");
        rst = 1'b0; #1;
        chk("arst_idle.imem_req", 32'(imem_req), 32'd0);
        tick;
        chk("arst_fetch.imem_req", 32'(imem_req), 32'd1);
        tick;
        $display("step: fetch after reset");
        chk_ifid("postrst", 1'b1, 32'h0, 6'b000001);
        chk("postrst.fetch_count", 32'(fetch_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 6'b111111: opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  downstream decode/control stage cannot accept a new instruction this cycle.
REQ-006 flush  input  1  invalidate the IF/ID register.
REQ-007 redirect  input  1  load a new PC; the in-flight fetch is discarded.
REQ-008 redirect_pc  input  32  target PC, sampled when redirect=1.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  fetch address, equal to the current PC.
REQ-011 imem_ready  input  1  memory returns imem_rdata this cycle; a transfer occurs when imem_req=1 and imem_ready=1.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-014 if_pc  output  32  PC of the instruction held in IF/ID.
REQ-015 op  output  6  IF/ID bits [31:26]; drives the control unit opcode input.
REQ-016 rs, rt, rd  output  5 each  IF/ID bits [25:21], [20:16], [15:11].
REQ-017 imm  output  16  IF/ID bits [15:0].
REQ-018 op_legal  output  1  if_valid=1 and op is one of 6'b000001 (add), 6'b000010 (sw), 6'b000100 (lw), or HALT_OP.
REQ-019 halted  output  1  fetch is stopped by HALT_OP.
REQ-020 fetch_count  output  16  number of accepted transfers; wraps from 16'hFFFF to 0.

Function
REQ-021 The FSM SHALL have three states: IDLE, FETCH, and HALT.
REQ-022 IDLE SHALL last exactly one cycle after reset deassertion, then move to FETCH.
REQ-023 FETCH: imem_req = !(stall && if_valid) && !redirect; in all other states imem_req=0.
REQ-024 On a transfer with no redirect: IF/ID <= imem_rdata, if_pc <= PC, if_valid <= 1, PC <= PC+4 (mod 2^32), fetch_count++.
REQ-025 Fetch-to-IF/ID latency SHALL be 1 cycle: the fields are valid the cycle after the transfer.
REQ-026 In FETCH with no transfer and stall=0: if_valid <= 0 (bubble); the IF/ID field values are held.
REQ-027 stall=1 with if_valid=1: all IF/ID outputs and the PC SHALL hold unchanged.
REQ-028 redirect=1: PC <= redirect_pc; if_valid <= 0; no transfer occurs that cycle; the state goes to FETCH, including from HALT.
REQ-029 Priority: redirect has precedence over stall. flush=1 forces if_valid <= 0 and has precedence over a same-cycle transfer (the word is dropped, but PC and fetch_count still advance).
REQ-030 A transfer whose imem_rdata[31:26] equals HALT_OP SHALL be captured normally, and the FSM moves to HALT; halted=1 while in HALT.
REQ-031 In HALT: no requests; PC is frozen; IF/ID follows REQ-026/027 with no new transfers.
REQ-032 op_legal SHALL be combinational from if_valid and op; it is 0 whenever if_valid=0.
REQ-033 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-034 On rst=1 (asynchronous): state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, op/rs/rt/rd/imm=0, op_legal=0, halted=0, fetch_count=0.
REQ-035 Reset asserted mid-fetch SHALL abandon the transfer immediately; a ready arriving during reset SHALL be ignored.

Verification
REQ-036 Reset release, imem_ready tied 1, memory returns 32'h0400_0000 at address 0 -> imem_req rises 1 cycle after release; the next cycle shows op=6'b000001, if_pc=0, op_legal=1, and imem_addr=4.
REQ-037 Back-to-back words add/sw/lw at 0/4/8 -> op sequence 000001, 000010, 000100 on consecutive cycles; fetch_count=3.
REQ-038 stall=1 for 3 cycles while if_valid=1 -> imem_req=0 and op/if_pc are stable; fetching resumes the cycle after stall falls.
REQ-039 redirect=1, redirect_pc=32'h40, in the same cycle as imem_ready=1 -> that word is discarded; if_valid=0 next cycle; the next imem_addr=32'h40.
REQ-040 Word 32'hFC00_0000 fetched -> halted=1 and imem_req stays 0 for 10 cycles; then redirect to 32'h0 -> fetching resumes.
REQ-041 rst pulsed mid-operation with PC=32'h20 and if_valid=1 -> all outputs take the REQ-034 values asynchronously, before the next clock edge.
